// File: rtl/ibex_rf_wb_pkg.sv
// rtl/ibex_rf_wb_pkg.sv - shared types for the register-file writeback buffer
// Source selectors, load FSM states, the write entry and RV32E address folding.
package ibex_rf_wb_pkg;

  localparam int unsigned WbDataWidth = 32;

  typedef enum logic [1:0] {WB_NONE, WB_LOAD, WB_HOLD, WB_EX} wb_src_e;

  typedef enum logic {LD_IDLE, LD_WAIT} ld_state_e;

  typedef struct packed {
    logic                   valid;
    logic [4:0]             waddr;
    logic [WbDataWidth-1:0] wdata;
  } wb_entry_t;

  // RV32E has only x0-x15, so bit 4 is dropped from every address.
  function automatic logic [4:0] rf_addr_mask(input logic [4:0] addr, input logic rv32e);
    return {addr[4] & ~rv32e, addr[3:0]};
  endfunction

endpackage

// File: rtl/ibex_rf_wb_fwd.sv
// rtl/ibex_rf_wb_fwd.sv - operand forwarding compare/mux for one read port
// The hold entry is younger than the output entry, so it wins on a double match.
module ibex_rf_wb_fwd
  import ibex_rf_wb_pkg::*;
(
  input  logic [4:0]             raddr_i,
  input  wb_entry_t              hold_i,
  input  wb_entry_t              out_i,
  output logic                   fwd_valid_o,
  output logic [WbDataWidth-1:0] fwd_data_o
);

  always_comb begin
    fwd_valid_o = 1'b0;
    fwd_data_o  = '0;
    if (raddr_i != 5'd0) begin
      if (hold_i.valid && hold_i.waddr == raddr_i) begin
        fwd_valid_o = 1'b1;
        fwd_data_o  = hold_i.wdata;
      end else if (out_i.valid && out_i.waddr == raddr_i) begin
        fwd_valid_o = 1'b1;
        fwd_data_o  = out_i.wdata;
      end
    end
  end

endmodule

// File: rtl/ibex_rf_wb_buffer.sv
// rtl/ibex_rf_wb_buffer.sv - writeback buffer feeding the register-file write port
// Merges EX results with one outstanding load, holds a colliding EX result, forwards.
module ibex_rf_wb_buffer
  import ibex_rf_wb_pkg::*;
#(
  parameter int unsigned DataWidth = WbDataWidth,
  parameter bit          RV32E     = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_valid_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 ld_req_i,
  input  logic [4:0]           ld_waddr_i,
  output logic                 ld_ready_o,
  input  logic                 ld_rvalid_i,
  input  logic [DataWidth-1:0] ld_rdata_i,
  input  logic                 ld_err_i,
  output logic                 ld_err_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 fwd_a_valid_o,
  output logic [DataWidth-1:0] fwd_a_data_o,
  output logic                 fwd_b_valid_o,
  output logic [DataWidth-1:0] fwd_b_data_o,
  output logic                 ld_hazard_o
);

  ld_state_e  state_q, state_d;
  logic [4:0] pend_rd_q, pend_rd_d;
  wb_entry_t  hold_q, hold_d;
  wb_entry_t  out_q, out_d;
  logic       ld_err_q, ld_err_d;
  wb_src_e    wb_src;

  logic [4:0] ex_addr, ld_addr, ra_addr, rb_addr;
  logic       ld_resp, ld_sel, waw_stall, ex_fire;

  assign ex_addr = rf_addr_mask(ex_waddr_i, RV32E);
  assign ld_addr = rf_addr_mask(ld_waddr_i, RV32E);
  assign ra_addr = rf_addr_mask(raddr_a_i, RV32E);
  assign rb_addr = rf_addr_mask(raddr_b_i, RV32E);

  assign ld_resp = (state_q == LD_WAIT) && ld_rvalid_i;
  // Errored loads and loads to x0 never compete for the write port.
  assign ld_sel  = ld_resp && !ld_err_i && (pend_rd_q != 5'd0);

  // A younger EX write to the pending load register must wait for the load data.
  assign waw_stall  = (state_q == LD_WAIT) && !ld_rvalid_i &&
                      (ex_addr == pend_rd_q) && (ex_addr != 5'd0);
  assign ex_ready_o = !hold_q.valid && !waw_stall;
  assign ex_fire    = ex_valid_i && ex_ready_o;
  assign ld_ready_o = (state_q == LD_IDLE);

  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    unique case (state_q)
      LD_IDLE: begin
        if (ld_req_i) begin
          state_d   = LD_WAIT;
          pend_rd_d = ld_addr;
        end
      end
      LD_WAIT: begin
        if (ld_rvalid_i) begin
          state_d = LD_IDLE;
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_comb begin
    wb_src   = WB_NONE;
    hold_d   = hold_q;
    out_d    = '0;
    ld_err_d = ld_resp && ld_err_i;

    if (ld_sel) begin
      wb_src = WB_LOAD;
      if (ex_fire && ex_addr != 5'd0) begin
        hold_d = '{valid: 1'b1, waddr: ex_addr, wdata: ex_wdata_i};
      end
    end else if (hold_q.valid) begin
      wb_src = WB_HOLD;
    end else if (ex_fire && ex_addr != 5'd0) begin
      wb_src = WB_EX;
    end

    unique case (wb_src)
      WB_LOAD: out_d = '{valid: 1'b1, waddr: pend_rd_q, wdata: ld_rdata_i};
      WB_HOLD: begin
        out_d  = hold_q;
        hold_d = '0;
      end
      WB_EX:   out_d = '{valid: 1'b1, waddr: ex_addr, wdata: ex_wdata_i};
      default: out_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= LD_IDLE;
      pend_rd_q <= 5'd0;
      hold_q    <= '0;
      out_q     <= '0;
      ld_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      hold_q    <= hold_d;
      out_q     <= out_d;
      ld_err_q  <= ld_err_d;
    end
  end

  assign rf_we_o    = out_q.valid;
  assign rf_waddr_o = out_q.waddr;
  assign rf_wdata_o = out_q.wdata;
  assign ld_err_o   = ld_err_q;

  assign ld_hazard_o = (state_q == LD_WAIT) &&
                       (((ra_addr != 5'd0) && (ra_addr == pend_rd_q)) ||
                        ((rb_addr != 5'd0) && (rb_addr == pend_rd_q)));

  ibex_rf_wb_fwd u_fwd_a (
    .raddr_i    (ra_addr),
    .hold_i     (hold_q),
    .out_i      (out_q),
    .fwd_valid_o(fwd_a_valid_o),
    .fwd_data_o (fwd_a_data_o)
  );

  ibex_rf_wb_fwd u_fwd_b (
    .raddr_i    (rb_addr),
    .hold_i     (hold_q),
    .out_i      (out_q),
    .fwd_valid_o(fwd_b_valid_o),
    .fwd_data_o (fwd_b_data_o)
  );

  assert property (@(posedge clk_i) disable iff (rst_i) !(state_q == LD_WAIT && ld_req_i));
  assert property (@(posedge clk_i) disable iff (rst_i) !(state_q == LD_IDLE && ld_rvalid_i));

endmodule

// File: tb/tb_ibex_rf_wb_buffer.sv
// tb/tb_ibex_rf_wb_buffer.sv - self-checking bench for ibex_rf_wb_buffer
// Pending writes are modelled as an ordered queue drained one per cycle.
module tb_ibex_rf_wb_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ex_valid_i = 1'b0;
  logic [4:0]  ex_waddr_i = '0;
  logic [31:0] ex_wdata_i = '0;
  logic        ex_ready_o;
  logic        ld_req_i = 1'b0;
  logic [4:0]  ld_waddr_i = '0;
  logic        ld_ready_o;
  logic        ld_rvalid_i = 1'b0;
  logic [31:0] ld_rdata_i = '0;
  logic        ld_err_i = 1'b0;
  logic        ld_err_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [4:0]  raddr_a_i = '0;
  logic [4:0]  raddr_b_i = '0;
  logic        fwd_a_valid_o;
  logic [31:0] fwd_a_data_o;
  logic        fwd_b_valid_o;
  logic [31:0] fwd_b_data_o;
  logic        ld_hazard_o;

  ibex_rf_wb_buffer #(.DataWidth(32), .RV32E(1'b0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .ex_ready_o(ex_ready_o),
    .ld_req_i(ld_req_i), .ld_waddr_i(ld_waddr_i), .ld_ready_o(ld_ready_o),
    .ld_rvalid_i(ld_rvalid_i), .ld_rdata_i(ld_rdata_i), .ld_err_i(ld_err_i),
    .ld_err_o(ld_err_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
    .fwd_a_valid_o(fwd_a_valid_o), .fwd_a_data_o(fwd_a_data_o),
    .fwd_b_valid_o(fwd_b_valid_o), .fwd_b_data_o(fwd_b_data_o),
    .ld_hazard_o(ld_hazard_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  bit          m_wait;
  logic [4:0]  m_pend;
  wr_t         m_q[$];
  bit          m_out_v;
  wr_t         m_out;
  bit          m_err;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_wait  = 1'b0;
    m_pend  = '0;
    m_q.delete();
    m_out_v = 1'b0;
    m_out   = '{a: '0, d: '0};
    m_err   = 1'b0;
  endtask

  // Newest in-flight write to r wins: the queued entry is younger than the output.
  task automatic model_fwd(input logic [4:0] r, output bit v, output logic [31:0] d);
    v = 1'b0;
    d = '0;
    if (r != 5'd0) begin
      if (m_q.size() > 0 && m_q[0].a == r) begin
        v = 1'b1;
        d = m_q[0].d;
      end else if (m_out_v && m_out.a == r) begin
        v = 1'b1;
        d = m_out.d;
      end
    end
  endtask

  // Call at posedge+1; returns at the following posedge+1.
  task automatic run_cycle(input bit exv, input logic [4:0] exa, input logic [31:0] exd,
                           input bit lreq, input logic [4:0] la,
                           input bit lrv, input logic [31:0] ldat, input bit lerr,
                           input logic [4:0] ra, input logic [4:0] rb);
    bit          rdy, resp, fv;
    logic [31:0] fd;
    wr_t         w;

    check_eq("rf_we", rf_we_o, m_out_v);
    if (m_out_v) begin
      check_eq("rf_waddr", rf_waddr_o, m_out.a);
      check_eq("rf_wdata", rf_wdata_o, m_out.d);
    end
    check_eq("ld_err", ld_err_o, m_err);

    ex_valid_i = exv; ex_waddr_i = exa; ex_wdata_i = exd;
    ld_req_i = lreq; ld_waddr_i = la;
    ld_rvalid_i = lrv; ld_rdata_i = ldat; ld_err_i = lerr;
    raddr_a_i = ra; raddr_b_i = rb;
    #1;

    rdy = (m_q.size() == 0) && !(m_wait && !lrv && exa == m_pend && exa != 0);
    check_eq("ex_ready", ex_ready_o, rdy);
    check_eq("ld_ready", ld_ready_o, !m_wait);
    check_eq("ld_hazard", ld_hazard_o,
             m_wait && ((ra != 0 && ra == m_pend) || (rb != 0 && rb == m_pend)));
    model_fwd(ra, fv, fd);
    check_eq("fwd_a_valid", fwd_a_valid_o, fv);
    if (fv) check_eq("fwd_a_data", fwd_a_data_o, fd);
    model_fwd(rb, fv, fd);
    check_eq("fwd_b_valid", fwd_b_valid_o, fv);
    if (fv) check_eq("fwd_b_data", fwd_b_data_o, fd);

    resp = m_wait && lrv;
    if (resp && !lerr && m_pend != 0) begin
      w = '{a: m_pend, d: ldat};
      m_q.push_front(w);
    end
    if (exv && rdy && exa != 0) begin
      w = '{a: exa, d: exd};
      m_q.push_back(w);
    end
    if (m_q.size() > 0) begin
      m_out_v = 1'b1;
      m_out   = m_q.pop_front();
    end else begin
      m_out_v = 1'b0;
    end
    m_err = resp && lerr;
    if (!m_wait && lreq) begin
      m_wait = 1'b1;
      m_pend = la;
    end else if (resp) begin
      m_wait = 1'b0;
    end

    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_cycle(input logic [4:0] ra, input logic [4:0] rb);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, ra, rb);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_we", rf_we_o, 0);
    check_eq("rst_err", ld_err_o, 0);
    check_eq("rst_wdata", rf_wdata_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // EX write appears one cycle later and is forwarded from the output register
    run_cycle(1, 5, 32'hA5A5_0001, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t1_we", rf_we_o, 1);
    check_eq("t1_wdata", rf_wdata_o, 32'hA5A5_0001);
    idle_cycle(5, 0);

    // load response collides with EX: load first, EX from hold
    run_cycle(0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
    run_cycle(1, 3, 32'h99, 0, 0, 1, 32'h1234, 0, 3, 7);
    check_eq("t2_waddr", rf_waddr_o, 7);
    check_eq("t2_wdata", rf_wdata_o, 32'h1234);
    check_eq("t2_hold_ready", ex_ready_o, 0);
    idle_cycle(3, 7);
    check_eq("t2_waddr2", rf_waddr_o, 3);
    check_eq("t2_wdata2", rf_wdata_o, 32'h99);

    // WAW stall against the pending load register
    run_cycle(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    run_cycle(1, 9, 32'hBEEF, 0, 0, 0, 0, 0, 0, 9);
    check_eq("t3_stall", ex_ready_o, 0);
    check_eq("t3_hazard", ld_hazard_o, 1);
    run_cycle(1, 9, 32'hBEEF, 0, 0, 0, 0, 0, 0, 9);
    run_cycle(1, 9, 32'hBEEF, 0, 0, 1, 32'h5555, 0, 9, 9);
    check_eq("t3_wdata1", rf_wdata_o, 32'h5555);
    idle_cycle(9, 0);
    check_eq("t3_wdata2", rf_wdata_o, 32'hBEEF);

    // x0 writes are accepted and dropped
    run_cycle(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t4_we", rf_we_o, 0);
    idle_cycle(0, 0);

    // errored load: no write, one-cycle error pulse
    run_cycle(0, 0, 0, 1, 4, 0, 0, 0, 0, 4);
    run_cycle(0, 0, 0, 0, 0, 1, 32'hDEAD, 1, 4, 0);
    check_eq("t5_err", ld_err_o, 1);
    check_eq("t5_we", rf_we_o, 0);
    check_eq("t5_ready", ld_ready_o, 1);
    idle_cycle(4, 0);

    // asynchronous reset while the hold register is full
    run_cycle(0, 0, 0, 1, 6, 0, 0, 0, 0, 0);
    run_cycle(1, 8, 32'h88, 0, 0, 1, 32'h66, 0, 0, 0);
    ex_valid_i = 0; ld_rvalid_i = 0; raddr_a_i = 8; raddr_b_i = 6;
    #1;
    check_eq("t6_pre_fwd", fwd_a_valid_o, 1);
    rst_i = 1'b1;
    #1;
    check_eq("t6_we", rf_we_o, 0);
    check_eq("t6_waddr", rf_waddr_o, 0);
    check_eq("t6_wdata", rf_wdata_o, 0);
    check_eq("t6_fwd_a", fwd_a_valid_o, 0);
    check_eq("t6_fwd_b", fwd_b_valid_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check_eq("t6_ld_ready", ld_ready_o, 1);
    check_eq("t6_ex_ready", ex_ready_o, 1);
    model_reset();
    @(posedge clk_i);
    #1;

    // randomized traffic with legal load handshakes
    for (int i = 0; i < 3000; i++) begin
      bit lreq, lrv;
      lreq = !m_wait && ($urandom_range(0, 3) == 0);
      lrv  = m_wait && ($urandom_range(0, 2) == 0);
      run_cycle($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                lreq, 5'($urandom_range(0, 7)),
                lrv, $urandom, ($urandom_range(0, 7) == 0),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle_cycle(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
